row_col_matrix_multiplier: RTL and testbench

//  Sequential 32-bit integer matrix multiplier computing R = A x B.
//  A is m x n, B is n x m, R is m x m; all matrices live in external memories.

---
 rtl/row_col_matrix_multiplier_if.sv | 31 +++
 rtl/row_col_matrix_multiplier.sv | 127 ++++++++++++
 tb/tb_row_col_matrix_multiplier.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/row_col_matrix_multiplier_if.sv
// Operand-read, result read-modify-write and control signals of the matrix multiplier.
// The master modport is the multiplier; the slave modport is the memory/consumer side.
interface row_col_matrix_multiplier_if #(
  parameter int m_len = 2,
  parameter int n_len = 3
);
  logic             start;
  logic [31:0]      a_in;
  logic [31:0]      b_in;
  logic [31:0]      current_element;
  logic             z_ack;
  logic [m_len-1:0] a_i;
  logic [n_len-1:0] a_j;
  logic [n_len-1:0] b_i;
  logic [m_len-1:0] b_j;
  logic [31:0]      z_out;
  logic [m_len-1:0] z_i;
  logic [m_len-1:0] z_j;
  logic             z_stb;
  logic             done;

  modport master (
    input  start, a_in, b_in, current_element, z_ack,
    output a_i, a_j, b_i, b_j, z_out, z_i, z_j, z_stb, done
  );

  modport slave (
    output start, a_in, b_in, current_element, z_ack,
    input  a_i, a_j, b_i, b_j, z_out, z_i, z_j, z_stb, done
  );
endinterface

// File: rtl/row_col_matrix_multiplier.sv
// Sequential R = A x B multiplier: one product per handshake, accumulated into R
// through a read-modify-write of the external result memory.
module row_col_matrix_multiplier #(
  parameter int n     = 8,
  parameter int m     = 4,
  parameter int m_len = $clog2(m),
  parameter int n_len = $clog2(n)
) (
  input logic                       clk,
  input logic                       rst,
  row_col_matrix_multiplier_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MAC,
    WAIT_ACK,
    RELEASE,
    DONE
  } state_t;

  localparam logic [m_len-1:0] M_LAST = m_len'(m - 1);
  localparam logic [n_len-1:0] N_LAST = n_len'(n - 1);

  state_t           state, state_nx;
  logic [m_len-1:0] i_q, j_q;
  logic [n_len-1:0] k_q;
  logic [31:0]      z_q;
  logic             stb_q;

  logic clr_idx, adv_idx, load_z, drop_stb, last;

  assign last = (i_q == M_LAST) && (j_q == M_LAST) && (k_q == N_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // RELEASE waits for z_ack to fall so a lingering ack cannot retire the next product.
  always_comb begin
    state_nx = state;
    clr_idx  = 1'b0;
    adv_idx  = 1'b0;
    load_z   = 1'b0;
    drop_stb = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          clr_idx  = 1'b1;
          state_nx = FETCH;
        end
      end
      FETCH: state_nx = MAC;
      MAC: begin
        load_z   = 1'b1;
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.z_ack) begin
          drop_stb = 1'b1;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.z_ack) begin
          if (last) begin
            state_nx = DONE;
          end else begin
            adv_idx  = 1'b1;
            state_nx = FETCH;
          end
        end
      end
      DONE: begin
        if (!bus.start) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
      z_q   <= '0;
      stb_q <= 1'b0;
    end else begin
      if (clr_idx) begin
        i_q <= '0;
        j_q <= '0;
        k_q <= '0;
      end else if (adv_idx) begin
        if (k_q == N_LAST) begin
          k_q <= '0;
          if (j_q == M_LAST) begin
            j_q <= '0;
            i_q <= i_q + m_len'(1);
          end else begin
            j_q <= j_q + m_len'(1);
          end
        end else begin
          k_q <= k_q + n_len'(1);
        end
      end
      if (load_z) begin
        z_q   <= bus.current_element + bus.a_in * bus.b_in;
        stb_q <= 1'b1;
      end else if (drop_stb) begin
        stb_q <= 1'b0;
      end
    end
  end

  assign bus.a_i   = i_q;
  assign bus.z_i   = i_q;
  assign bus.a_j   = k_q;
  assign bus.b_i   = k_q;
  assign bus.b_j   = j_q;
  assign bus.z_j   = j_q;
  assign bus.z_out = z_q;
  assign bus.z_stb = stb_q;
  assign bus.done  = (state == DONE);

endmodule

// File: tb/tb_row_col_matrix_multiplier.sv
// Randomized and directed checks of the matrix multiplier against a plain-arithmetic
// model, with memory models for A, B and the acknowledging result memory R.
module tb_row_col_matrix_multiplier;

  localparam int M     = 4;
  localparam int N     = 8;
  localparam int ML    = 2;
  localparam int NL    = 3;
  localparam int BOUND = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  row_col_matrix_multiplier_if #(.m_len(ML), .n_len(NL)) bus ();

  row_col_matrix_multiplier #(.n(N), .m(M), .m_len(ML), .n_len(NL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem_a [M][N];
  logic [31:0] mem_b [N][M];
  logic [31:0] mem_r [M][M];

  assign bus.a_in            = mem_a[bus.a_i][bus.a_j];
  assign bus.b_in            = mem_b[bus.b_i][bus.b_j];
  assign bus.current_element = mem_r[bus.z_i][bus.z_j];

  logic auto_ack, manual_ack, clr_req;

  // Result memory: registered ack, writes R whenever it acks a valid strobe.
  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < M; j++)
          mem_r[i][j] <= '0;
      bus.z_ack <= 1'b0;
    end else begin
      if ((auto_ack ? bus.z_stb : manual_ack) && bus.z_stb)
        mem_r[bus.z_i][bus.z_j] <= bus.z_out;
      bus.z_ack <= auto_ack ? bus.z_stb : manual_ack;
    end
  end

  typedef struct {
    int          zi;
    int          zj;
    int          k;
    int          bi;
    logic [31:0] v;
  } ent_t;

  ent_t stb_log[$];
  logic stb_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.z_stb && !stb_prev)
      stb_log.push_back('{int'(bus.z_i), int'(bus.z_j), int'(bus.a_j), int'(bus.b_i), bus.z_out});
    stb_prev <= bus.z_stb;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_partial(int i, int j, int kmax);
    longint s = 0;
    for (int k = 0; k <= kmax; k++)
      s += longint'($signed(mem_a[i][k])) * longint'($signed(mem_b[k][j]));
    return s[31:0];
  endfunction

  task automatic zero_r();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  task automatic clear_ab();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < N; k++) begin
        mem_a[i][k] = '0;
        mem_b[k][i] = '0;
      end
  endtask

  task automatic begin_run(output int base);
    zero_r();
    base  = stb_log.size();
    bus.start = 1'b1;
  endtask

  task automatic finish_run(input string tag, input int base);
    int cnt, idx;
    for (int c = 0; c < BOUND && !bus.done; c++) @(negedge clk);
    check({tag, "_done"}, bus.done, 1'b1);
    cnt = stb_log.size() - base;
    check({tag, "_stb_count"}, cnt, M * M * N);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        check($sformatf("%s_r%0d%0d", tag, i, j), mem_r[i][j], ref_partial(i, j, N - 1));
    if (cnt == M * M * N) begin
      idx = base;
      for (int i = 0; i < M; i++)
        for (int j = 0; j < M; j++)
          for (int k = 0; k < N; k++) begin
            check({tag, "_seq_zi"}, stb_log[idx].zi, i);
            check({tag, "_seq_zj"}, stb_log[idx].zj, j);
            check({tag, "_seq_k"},  stb_log[idx].k,  k);
            check({tag, "_seq_bi"}, stb_log[idx].bi, k);
            check({tag, "_seq_val"}, stb_log[idx].v, ref_partial(i, j, k));
            idx++;
          end
    end
    bus.start = 1'b0;
    for (int c = 0; c < 10 && bus.done; c++) @(negedge clk);
    check({tag, "_done_clear"}, bus.done, 1'b0);
  endtask

  initial begin
    int base;
    logic [31:0] hold_z;
    rst = 1'b0; bus.start = 1'b0; auto_ack = 1'b1; manual_ack = 1'b0; clr_req = 1'b0;
    clear_ab();
    repeat (3) @(negedge clk);
    check("rst_stb",  bus.z_stb, 1'b0);
    check("rst_done", bus.done,  1'b0);
    check("rst_zout", bus.z_out, '0);
    check("rst_addr", {bus.a_i, bus.a_j, bus.b_i, bus.b_j, bus.z_i, bus.z_j}, '0);
    rst = 1'b1;
    @(negedge clk);

    // Identity: A=[I|0], B=[I;0]; also explicit order of the first strobes.
    clear_ab();
    for (int i = 0; i < M; i++) begin
      mem_a[i][i] = 32'd1;
      mem_b[i][i] = 32'd1;
    end
    begin_run(base);
    finish_run("ident", base);
    for (int q = 0; q <= N; q++) begin
      check("order_zi", stb_log[base + q].zi, 0);
      check("order_zj", stb_log[base + q].zj, (q == N) ? 1 : 0);
      check("order_k",  stb_log[base + q].k,  (q == N) ? 0 : q);
    end

    // All ones: every element 8, last group counts up 1..8.
    for (int i = 0; i < M; i++)
      for (int k = 0; k < N; k++) begin
        mem_a[i][k] = 32'd1;
        mem_b[k][i] = 32'd1;
      end
    begin_run(base);
    finish_run("ones", base);
    for (int q = 0; q < N; q++)
      check("ones_last_grp", stb_log[base + M * M * N - N + q].v, q + 1);

    // Wrap-around products.
    clear_ab();
    mem_a[0][0] = 32'h0001_0000;
    mem_b[0][0] = 32'h0001_0000;
    begin_run(base);
    finish_run("wrap", base);
    check("wrap_r00", mem_r[0][0], 32'h0);
    mem_a[0][0] = -32'sd3;
    mem_b[0][0] = 32'd5;
    begin_run(base);
    finish_run("neg", base);
    check("neg_r00", mem_r[0][0], 32'hFFFF_FFF1);

    // Handshake: stall, then a 2-cycle ack pulse retires one product.
    for (int i = 0; i < M; i++)
      for (int k = 0; k < N; k++) begin
        mem_a[i][k] = $urandom;
        mem_b[k][i] = $urandom;
      end
    auto_ack = 1'b0;
    begin_run(base);
    for (int c = 0; c < 20 && !bus.z_stb; c++) @(negedge clk);
    check("hs_stb_seen", bus.z_stb, 1'b1);
    hold_z = ref_partial(0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hs_hold_stb",  bus.z_stb, 1'b1);
      check("hs_hold_zout", bus.z_out, hold_z);
      check("hs_hold_addr", {bus.a_i, bus.a_j, bus.b_j}, '0);
    end
    manual_ack = 1'b1;
    repeat (2) @(negedge clk);
    manual_ack = 1'b0;
    for (int c = 0; c < 20 && stb_log.size() < base + 2; c++) @(negedge clk);
    check("hs_second_stb", stb_log.size(), base + 2);
    if (stb_log.size() >= base + 2) check("hs_one_retired", stb_log[base + 1].k, 1);
    repeat (5) @(negedge clk);
    check("hs_no_extra", stb_log.size(), base + 2);
    auto_ack = 1'b1;
    finish_run("hs", base);

    // Reset mid-run at k=3, then a clean restart.
    begin_run(base);
    for (int c = 0; c < BOUND && !(bus.z_stb && bus.a_j == 3); c++) @(negedge clk);
    check("mid_k3_reached", bus.a_j, 3);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_stb",  bus.z_stb, 1'b0);
    check("mid_rst_done", bus.done,  1'b0);
    check("mid_rst_addr", {bus.a_i, bus.a_j, bus.b_i, bus.b_j, bus.z_i, bus.z_j}, '0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    begin_run(base);
    finish_run("restart", base);

    // Further random matrices, including small signed values.
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < M; i++)
        for (int k = 0; k < N; k++) begin
          mem_a[i][k] = (t == 0) ? $urandom : 32'($signed($urandom_range(200)) - 100);
          mem_b[k][i] = (t == 0) ? $urandom : 32'($signed($urandom_range(200)) - 100);
        end
      begin_run(base);
      finish_run($sformatf("rand%0d", t), base);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
